// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that locks one byte-stream requester per packet onto a single UART transmitter.
// Optional idle-owner release is compiled in when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NUM_REQ-1:0]     i_req_valid,
    input  logic [8*NUM_REQ-1:0]   i_req_data,
    input  logic [NUM_REQ-1:0]     i_req_last,
    output logic [NUM_REQ-1:0]     o_req_ready,
    output logic [7:0]             o_tx_data,
    output logic                   o_tx_valid,
    input  logic                   i_tx_ready,
    output logic [NUM_REQ-1:0]     o_grant,
    output logic                   o_busy,
    output logic                   o_timeout
);
    localparam int OW = $clog2(NUM_REQ);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t               state, state_nxt;
    logic [OW-1:0]        owner, owner_nxt;
    logic [OW-1:0]        last_owner, last_owner_nxt;
    logic [OW-1:0]        sel, cand;
    logic [NUM_REQ-1:0]   grant, grant_nxt;
    logic                 found;
    logic                 owner_ready;
    logic                 xfer;
    logic                 tmo_hit;
    logic [7:0]           req_bytes [NUM_REQ];
    logic [7:0]           tx_data;
    logic                 tx_valid;

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("uart_tx_arbiter: NUM_REQ must be 2..8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign req_bytes[k] = i_req_data[8*k +: 8];
    end

    // Round-robin search starting just after the previous owner.
    always_comb begin
        sel   = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = OW'((int'(last_owner) + i) % NUM_REQ);
            if (!found && i_req_valid[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // The output register can take a new byte when empty or draining this cycle.
    assign owner_ready = ~tx_valid | i_tx_ready;
    assign xfer        = (state == LOCK) & i_req_valid[owner] & owner_ready;

    always_comb begin
        o_req_ready = '0;
        if (state == LOCK) begin
            o_req_ready[owner] = owner_ready;
        end
    end

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        grant_nxt      = grant;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = LOCK;
                    owner_nxt = sel;
                    grant_nxt = NUM_REQ'(1) << sel;
                end
            end
            LOCK: begin
                if ((xfer && i_req_last[owner]) || tmo_hit) begin
                    state_nxt      = IDLE;
                    last_owner_nxt = owner;
                    grant_nxt      = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= OW'(NUM_REQ - 1);
            grant      <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
            grant      <= grant_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
        end else if (xfer) begin
            tx_valid <= 1'b1;
            tx_data  <= req_bytes[owner];
        end else if (i_tx_ready) begin
            tx_valid <= 1'b0;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] tmo_cnt;
    logic          tmo_q;

    // Fires on the cycle that completes TIMEOUT_CYCLES consecutive idle-owner cycles.
    assign tmo_hit = (state == LOCK) & ~i_req_valid[owner] &
                     (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmo_cnt <= '0;
            tmo_q   <= 1'b0;
        end else begin
            tmo_q <= tmo_hit;
            if (state != LOCK || xfer || tmo_hit) begin
                tmo_cnt <= '0;
            end else if (!i_req_valid[owner]) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    assign o_timeout = tmo_q;
`else
    assign tmo_hit   = 1'b0;
    assign o_timeout = 1'b0;
`endif

    assign o_tx_data  = tx_data;
    assign o_tx_valid = tx_valid;
    assign o_grant    = grant;
    assign o_busy     = (state == LOCK);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized packet traffic scored against
// a packet-level round-robin model of the expected byte stream.
module tb_uart_tx_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_ready = 1'b1;
    logic [N-1:0]   grant;
    logic           busy;
    logic           timeout;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .i_req_last  (req_last),
        .o_req_ready (req_ready),
        .o_tx_data   (tx_data),
        .o_tx_valid  (tx_valid),
        .i_tx_ready  (tx_ready),
        .o_grant     (grant),
        .o_busy      (busy),
        .o_timeout   (timeout)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] src_d [N][64];
    bit         src_l [N][64];
    int         src_n [N];
    int         src_p [N];
    logic [7:0] out_q [$];
    logic [7:0] exp_q [$];
    int         acc_cyc [$];
    int         cyc_n = 0;
    int         viol = 0;
    int         tmo_seen = 0;
    int         m_last = N - 1;
    bit         rand_ready = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            if (src_p[k] < src_n[k]) begin
                req_valid[k]       = 1'b1;
                req_data[8*k +: 8] = src_d[k][src_p[k]];
                req_last[k]        = src_l[k][src_p[k]];
            end else begin
                req_valid[k]       = 1'b0;
                req_data[8*k +: 8] = 8'h00;
                req_last[k]        = 1'b0;
            end
        end
    endtask

    task automatic clear_src();
        for (int k = 0; k < N; k++) begin
            src_n[k] = 0;
            src_p[k] = 0;
        end
    endtask

    task automatic add_byte(input int k, input logic [7:0] d, input bit l);
        src_d[k][src_n[k]] = d;
        src_l[k][src_n[k]] = l;
        src_n[k]++;
    endtask

    function automatic bit srcs_empty();
        for (int k = 0; k < N; k++) if (src_p[k] < src_n[k]) return 1'b0;
        return 1'b1;
    endfunction

    // One clock: observe handshakes at the falling edge, advance sources after the rising edge.
    task automatic cyc();
        logic [N-1:0] fire;
        @(negedge clk);
        fire = req_valid & req_ready;
        if ($countones(grant) > 1) viol++;
        if ((req_ready & ~grant) != '0) viol++;
        if ((fire & ~grant) != '0) viol++;
        if (tx_valid && tx_ready) begin
            out_q.push_back(tx_data);
            acc_cyc.push_back(cyc_n);
        end
        if (timeout) tmo_seen++;
        @(posedge clk);
        #1;
        cyc_n++;
        for (int k = 0; k < N; k++) if (fire[k]) src_p[k]++;
        if (rand_ready) tx_ready = ($urandom_range(0, 3) != 0);
        drive();
    endtask

    // Packets are served whole, rotating from the requester after the previous owner.
    task automatic model();
        int  mp [N];
        int  pick;
        bit  more;
        bit  done_pkt;
        for (int j = 0; j < N; j++) mp[j] = src_p[j];
        exp_q.delete();
        more = 1'b1;
        while (more) begin
            pick = -1;
            for (int i = 1; i <= N; i++) begin
                if (pick < 0 && mp[(m_last + i) % N] < src_n[(m_last + i) % N])
                    pick = (m_last + i) % N;
            end
            if (pick < 0) begin
                more = 1'b0;
            end else begin
                done_pkt = 1'b0;
                while (!done_pkt && mp[pick] < src_n[pick]) begin
                    exp_q.push_back(src_d[pick][mp[pick]]);
                    done_pkt = src_l[pick][mp[pick]];
                    mp[pick]++;
                end
                m_last = pick;
            end
        end
    endtask

    task automatic drain(input string tag, input int maxc);
        int c = 0;
        while (!(srcs_empty() && !tx_valid && !busy) && c < maxc) begin
            cyc();
            c++;
        end
        check({tag, "_drain_in_time"}, 32'(c < maxc), 32'd1);
    endtask

    task automatic cmp_stream(input string tag);
        check({tag, "_stream_len"}, out_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), out_q[i], exp_q[i]);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        clear_src();
        drive();
        out_q.delete();
        acc_cyc.delete();
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        m_last = N - 1;
    endtask

    initial begin
        int c;
        int npk;
        int len;

        // Reset values, with requesters asserting valid while reset is held
        clear_src();
        req_valid = '1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_timeout", timeout, 0);
        drive();
        rst_n  = 1'b1;
        m_last = N - 1;

        // Requesters 0 and 2 together: 0 first, then 2 after one arbitration cycle
        add_byte(0, 8'h41, 1'b0);
        add_byte(0, 8'h42, 1'b1);
        add_byte(2, 8'h5a, 1'b0);
        add_byte(2, 8'ha5, 1'b1);
        model();
        drive();
        cyc();
        check("s1_grant_first", grant, 4'b0001);
        check("s1_busy", busy, 1);
        cyc();
        cyc();
        check("s1_grant_gap", grant, 4'b0000);
        check("s1_busy_gap", busy, 0);
        cyc();
        check("s1_grant_next", grant, 4'b0100);
        drain("s1", 40);
        cmp_stream("s1");

        // All four valid with single-byte packets: grants rotate 0,1,2,3,0
        do_reset();
        add_byte(0, 8'h10, 1'b1);
        add_byte(0, 8'h14, 1'b1);
        add_byte(1, 8'h11, 1'b1);
        add_byte(2, 8'h12, 1'b1);
        add_byte(3, 8'h13, 1'b1);
        model();
        drive();
        for (int i = 0; i < 10; i++) begin
            cyc();
            check($sformatf("s2_grant%0d", i), grant,
                  (i % 2 == 0) ? (32'd1 << ((i / 2) % N)) : 32'd0);
        end
        drain("s2", 40);
        cmp_stream("s2");
        check("s2_accepts", acc_cyc.size(), 5);
        for (int i = 0; i + 1 < acc_cyc.size(); i++)
            check($sformatf("s2_spacing%0d", i), acc_cyc[i + 1] - acc_cyc[i], 2);

        // Eight-byte stream with a three-cycle downstream stall
        out_q.delete();
        clear_src();
        for (int i = 0; i < 8; i++) add_byte(1, 8'(i), i == 7);
        model();
        drive();
        repeat (4) cyc();
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check($sformatf("s3_hold_data%0d", i), tx_data, 8'h02);
            check($sformatf("s3_hold_valid%0d", i), tx_valid, 1);
            check($sformatf("s3_stall_ready%0d", i), req_ready, 0);
        end
        tx_ready = 1'b1;
        drain("s3", 40);
        cmp_stream("s3");

        // Randomized packets on every requester with random downstream backpressure
        for (int r = 0; r < 3; r++) begin
            out_q.delete();
            clear_src();
            for (int k = 0; k < N; k++) begin
                npk = $urandom_range(1, 3);
                for (int p = 0; p < npk; p++) begin
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++)
                        add_byte(k, 8'($urandom_range(0, 255)), b == len - 1);
                end
            end
            model();
            drive();
            rand_ready = 1'b1;
            drain($sformatf("rnd%0d", r), 400);
            rand_ready = 1'b0;
            tx_ready   = 1'b1;
            cmp_stream($sformatf("rnd%0d", r));
        end

        // Reset asserted while the third of five bytes is offered
        out_q.delete();
        clear_src();
        for (int i = 0; i < 5; i++) add_byte(3, 8'ha0 + 8'(i), i == 4);
        drive();
        repeat (3) cyc();
        #2;
        rst_n = 1'b0;
        #1;
        check("s4_grant", grant, 0);
        check("s4_busy", busy, 0);
        check("s4_tx_valid", tx_valid, 0);
        check("s4_tx_data", tx_data, 0);
        check("s4_req_ready", req_ready, 0);
        clear_src();
        out_q.delete();
        add_byte(3, 8'hc3, 1'b0);
        add_byte(3, 8'hc4, 1'b1);
        add_byte(1, 8'hb1, 1'b1);
        m_last = N - 1;
        model();
        drive();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc();
        check("s4_grant_after", grant, 4'b0010);
        drain("s4", 40);
        cmp_stream("s4");

        // Owner goes quiet after two bytes without a last marker
        do_reset();
        add_byte(0, 8'h11, 1'b0);
        add_byte(0, 8'h22, 1'b0);
        add_byte(1, 8'h33, 1'b1);
        model();
        drive();
        repeat (3) cyc();
`ifdef UART_ARB_TIMEOUT_EN
        c = 0;
        do begin
            cyc();
            c++;
        end while (!timeout && c < 40);
        check("s5_timeout_delay", c, 16);
        check("s5_busy_released", busy, 0);
        check("s5_grant_released", grant, 0);
        cyc();
        check("s5_timeout_pulse", timeout, 0);
        check("s5_grant_next", grant, 4'b0010);
        drain("s5", 40);
        cmp_stream("s5");
`else
        tmo_seen = 0;
        c = 0;
        repeat (30) begin
            cyc();
            c++;
        end
        check("s5_cycles", c, 30);
        check("s5_busy_held", busy, 1);
        check("s5_grant_held", grant, 4'b0001);
        check("s5_no_timeout", tmo_seen, 0);
        check("s5_nonowner_ready", req_ready[1], 0);
        check("s5_drained", out_q.size(), 2);
        if (out_q.size() == 2) begin
            check("s5_byte0", out_q[0], 8'h11);
            check("s5_byte1", out_q[1], 8'h22);
        end
        do_reset();
`endif

        check("ownership", viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
